// File: rtl/piso_serializer_if.sv
// Parallel load handshake and serial stream bundle for piso_serializer.
// master: upstream/downstream driver; slave: the serializer.
interface piso_serializer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             ser_en;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             frame_last;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output load_valid, load_data, ser_en,
    input  load_ready, ser_out, ser_valid,
    input  frame_start, frame_last, frame_cnt
  );

  modport slave (
    input  load_valid, load_data, ser_en,
    output load_ready, ser_out, ser_valid,
    output frame_start, frame_last, frame_cnt
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out word serializer, one bit per enabled clock.
// Ports: clk, clr (sync active-high), bus (slave: load + serial side).
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             clr,
  piso_serializer_if.slave bus
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             ser_valid;
  logic             head_bit;
  logic             is_last;
  logic             take;
  logic             ready;
  logic             accept;
  logic [WIDTH-1:0] shifted;

  always_comb begin
    ser_valid = (state_q == SHIFT);
    head_bit  = (MSB_FIRST != 0) ? shreg_q[WIDTH-1]
                                 : shreg_q[0];
    is_last   = ser_valid && (bit_cnt_q == LAST_IDX);
    take      = ser_valid && bus.ser_en;
    // A new word may land on the edge that consumes
    // the last bit, so frames run back to back.
    ready     = !ser_valid || (is_last && bus.ser_en);
    accept    = bus.load_valid && ready;
    shifted   = (MSB_FIRST != 0)
              ? {shreg_q[WIDTH-2:0], 1'b0}
              : {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (take) begin
      if (is_last) begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        state_d     = IDLE;
      end else begin
        shreg_d   = shifted;
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
    if (accept) begin
      shreg_d   = bus.load_data;
      bit_cnt_d = '0;
      state_d   = SHIFT;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.ser_valid   = ser_valid;
  assign bus.ser_out     = ser_valid & head_bit;
  assign bus.frame_start = ser_valid && (bit_cnt_q == '0);
  assign bus.frame_last  = is_last;
  assign bus.load_ready  = ready;
  assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that converts WIDTH-bit words into a bit stream, one bit per enabled clock.
- Drives the d input of the downstream d_ff capture/delay chain.
- Valid/ready handshake on the parallel side; ser_en stall qualifier on the serial side.
- Supports back-to-back frames with no idle gap and keeps a wrapping count of completed frames.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  synchronous active-high reset, sampled on the rising edge of clk.
- load_valid  input  1  load_data is valid this cycle.
- load_data  input  WIDTH  parallel word to serialize.
- load_ready  output  1  block accepts a word this cycle.
- ser_en  input  1  downstream advance enable; the current bit is consumed when ser_valid && ser_en.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a frame bit.
- frame_start  output  1  current bit is the first bit of its frame.
- frame_last  output  1  current bit is the last bit of its frame.
- frame_cnt  output  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Registers:
  - state: IDLE or SHIFT.
  - shreg[WIDTH-1:0].
  - bit_cnt: $clog2(WIDTH) bits, counts bits consumed in the current frame.
  - frame_cnt.
- Reset: clr=1 at a clock edge sets state=IDLE, shreg=0, bit_cnt=0, frame_cnt=0.
  - clr has priority over every other input, including mid-frame. The partial frame is discarded and is not counted.
  - After that edge: ser_valid=0, ser_out=0, frame_start=0, frame_last=0, load_ready=1.
- All outputs are combinational decodes of registers and ser_en only. No combinational path from load_valid or load_data to any output.
  - ser_valid = (state==SHIFT).
  - ser_out = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. Forced to 0 when ser_valid=0.
  - frame_start = ser_valid && (bit_cnt==0).
  - frame_last = ser_valid && (bit_cnt==WIDTH-1).
  - load_ready = (state==IDLE) || (frame_last && ser_en).
- Accept: load_valid && load_ready.
  - shreg <= load_data, bit_cnt <= 0, state <= SHIFT.
  - The first bit appears on ser_out the cycle after the accept edge (latency 1).
- Advance (SHIFT, ser_en=1, not last bit):
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0],1'b0}.
  - MSB_FIRST=0: shreg <= {1'b0,shreg[WIDTH-1:1]}.
  - bit_cnt <= bit_cnt+1.
- Last bit consumed (frame_last && ser_en):
  - frame_cnt <= frame_cnt+1, wrapping from all-ones to 0.
  - If an accept occurs in the same cycle, the new word loads and state stays SHIFT, giving a gap-free frame boundary.
  - Otherwise state <= IDLE.
- Stall: in SHIFT with ser_en=0, all registers hold. ser_out, frame_start and frame_last stay stable.
- ser_en is ignored in IDLE.
- load_valid in SHIFT before the last bit is consumed is not accepted (load_ready=0). The upstream must hold load_data stable until accepted.
- Frame length is exactly WIDTH enabled cycles. Every frame asserts frame_start exactly once and frame_last exactly once.
- For WIDTH=2, frame_start and frame_last are on consecutive bits and are never simultaneous.

Test Plan:
- Reset: clr=1 for 2 cycles with load_valid=1 and load_data=8'hFF.
  - Required: ser_valid=0, ser_out=0, load_ready=1, frame_cnt=0, no word accepted.
- Single frame (WIDTH=8, MSB_FIRST=1): accept 8'hA5, ser_en=1 throughout.
  - Required: ser_out=1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept.
  - Required: frame_start on bit 1 only, frame_last on bit 8 only; then ser_valid=0 and frame_cnt=1.
- Back-to-back: load_valid held high with 8'hA5 then 8'h3C, ser_en=1.
  - Required: second word accepted on the frame_last cycle; 16 contiguous ser_valid cycles; bits 9..16 = 0,0,1,1,1,1,0,0; frame_cnt=2.
- Stall: 8'hA5 with ser_en=0 for the 3 cycles while bit 3 is presented.
  - Required: ser_out holds 1 for 4 cycles, frame spans 11 cycles, load_ready=0 throughout, frame_cnt=1 at end.
- LSB-first (MSB_FIRST=0): accept 8'h01.
  - Required: ser_out=1 then seven 0s.
- Mid-frame reset: clr=1 for one cycle while bit 5 of 8'hA5 is presented.
  - Required: next cycle ser_valid=0, load_ready=1, frame_cnt=0; a following load of 8'h3C serializes cleanly from bit 1.
